// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like memory port between the instruction
// and data requesters, holds a stalled request stable until it is accepted,
// and steers in-order responses back using a small ID FIFO.
module mem_port_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ID_INST = 1'b0,
        ID_DATA = 1'b1
    } req_id_e;

    logic             lock_valid_q, lock_valid_d;
    req_id_e          lock_id_q, lock_id_d;
    req_id_e          fifo_q [DEPTH];
    req_id_e          fifo_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    req_id_e grant;
    req_id_e head;
    logic    full;
    logic    push;
    logic    pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Grant selection, downstream request mux and zero-latency handshakes
    always_comb begin
        full    = (cnt_q == CNT_W'(DEPTH));
        grant   = lock_valid_q ? lock_id_q : (data_req ? ID_DATA : ID_INST);
        mem_req = ~reset & ~full & (lock_valid_q | inst_req | data_req);
        push    = mem_req & mem_addr_ok;
        pop     = ~reset & mem_data_ok & (cnt_q != '0);
        head    = fifo_q[rd_ptr_q];

        if (grant == ID_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else begin
            mem_wr    = 1'b0;
            mem_size  = 2'd2;
            mem_wstrb = 4'b0000;
            mem_addr  = inst_addr;
            mem_wdata = 32'h0;
        end

        inst_addr_ok = push & (grant == ID_INST);
        data_addr_ok = push & (grant == ID_DATA);
        inst_data_ok = pop & (head == ID_INST);
        data_data_ok = pop & (head == ID_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    // Next-state for lock, ID FIFO pointers/contents and outstanding count
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        fifo_d       = fifo_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;

        if (push) begin
            lock_valid_d     = 1'b0;
            fifo_d[wr_ptr_q] = grant;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end else if (mem_req) begin
            lock_valid_d = 1'b1;
            lock_id_d    = grant;
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= ID_INST;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    // ID FIFO storage; entries are only read when the count says they are live
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run, checked
// against a queue-based reference model of the arbiter's rules.
module tb_mem_port_arbiter;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending-grant lock plus a queue of issued requester IDs
    bit m_lock_v  = 1'b0;
    bit m_lock_id = 1'b0;
    int m_q[$];

    // Expectations for the cycle currently being presented
    bit          e_valid = 1'b0;
    bit          e_rst, e_req, e_acc, e_grant, e_pop;
    bit          e_iaok, e_daok, e_idok, e_ddok, e_wr;
    logic [1:0]  e_size;
    logic [3:0]  e_strb;
    logic [31:0] e_addr, e_wdata;

    // Advance the model by the cycle that was just presented
    task automatic commit();
        if (!e_valid) return;
        if (e_rst) begin
            m_lock_v = 1'b0;
            m_q.delete();
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (e_acc) begin
                m_q.push_back(int'(e_grant));
                m_lock_v = 1'b0;
            end else if (e_req) begin
                m_lock_v  = 1'b1;
                m_lock_id = e_grant;
            end
        end
        e_valid = 1'b0;
    endtask

    // Derive this cycle's expected outputs from the model and live inputs
    task automatic predict();
        e_rst   = reset;
        e_grant = m_lock_v ? m_lock_id : data_req;
        e_req   = !reset && (m_q.size() < int'(DEPTH)) && (m_lock_v || inst_req || data_req);
        e_acc   = e_req && mem_addr_ok;
        e_iaok  = e_acc && !e_grant;
        e_daok  = e_acc && e_grant;
        e_pop   = !reset && mem_data_ok && (m_q.size() > 0);
        e_idok  = 1'b0;
        e_ddok  = 1'b0;
        if (e_pop) begin
            e_idok = (m_q[0] == 0);
            e_ddok = (m_q[0] == 1);
        end
        if (e_grant) begin
            e_wr = data_wr; e_size = data_size; e_strb = data_wstrb;
            e_addr = data_addr; e_wdata = data_wdata;
        end else begin
            e_wr = 1'b0; e_size = 2'd2; e_strb = 4'b0000;
            e_addr = inst_addr; e_wdata = 32'h0;
        end
        e_valid = 1'b1;
    endtask

    task automatic step_begin();
        commit();
        @(negedge clk);
    endtask

    task automatic step_end();
        #1;
        predict();
    endtask

    task automatic idle();
        inst_req = 0; inst_addr = '0; data_req = 0; data_wr = 0; data_size = '0;
        data_wstrb = '0; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step_begin(); idle(); reset = 1;
            inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
            step_end();
            n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
            n_vec++; if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin n_err++; $display("FAIL reset_addr_ok got %b%b want 00", inst_addr_ok, data_addr_ok); end
            n_vec++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_err++; $display("FAIL reset_data_ok got %b%b want 00", inst_data_ok, data_data_ok); end
        end
        step_begin(); idle(); reset = 0; mem_data_ok = 1; step_end();
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL idle_mem_req got %b want 0", mem_req); end
        n_vec++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_err++; $display("FAIL stray_after_reset got %b%b want 00", inst_data_ok, data_data_ok); end
    endtask

    task automatic test_contention();
        step_begin(); idle();
        inst_req = 1; inst_addr = 32'h1c000100;
        data_req = 1; data_size = 2'd2; data_addr = 32'h1c000800; mem_addr_ok = 1;
        step_end();
        n_vec++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin n_err++; $display("FAIL cont_first got i=%b d=%b want i=0 d=1", inst_addr_ok, data_addr_ok); end
        n_vec++; if (mem_addr !== 32'h1c000800) begin n_err++; $display("FAIL cont_addr got %h want 1c000800", mem_addr); end
        step_begin(); data_req = 0; step_end();
        n_vec++; if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1c000100) begin n_err++; $display("FAIL cont_second got ok=%b addr=%h want 1 1c000100", inst_addr_ok, mem_addr); end
        step_begin(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11112222; step_end();
        n_vec++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin n_err++; $display("FAIL cont_resp0 got i=%b d=%b want i=0 d=1", inst_data_ok, data_data_ok); end
        n_vec++; if (data_rdata !== 32'h11112222) begin n_err++; $display("FAIL cont_rdata got %h want 11112222", data_rdata); end
        step_begin(); mem_rdata = 32'h33334444; step_end();
        n_vec++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin n_err++; $display("FAIL cont_resp1 got i=%b d=%b want i=1 d=0", inst_data_ok, data_data_ok); end
    endtask

    task automatic test_lock();
        step_begin(); idle(); inst_req = 1; inst_addr = 32'h1c000000; step_end();
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h1c000000 || inst_addr_ok !== 1'b0) begin n_err++; $display("FAIL lock_c1 got req=%b addr=%h ok=%b want 1 1c000000 0", mem_req, mem_addr, inst_addr_ok); end
        for (int c = 2; c <= 3; c++) begin
            step_begin(); data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h1c000900; step_end();
            n_vec++; if (mem_addr !== 32'h1c000000 || data_addr_ok !== 1'b0) begin n_err++; $display("FAIL lock_c%0d got addr=%h dok=%b want 1c000000 0", c, mem_addr, data_addr_ok); end
        end
        step_begin(); mem_addr_ok = 1; step_end();
        n_vec++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || mem_addr !== 32'h1c000000) begin n_err++; $display("FAIL lock_accept got i=%b d=%b addr=%h want 1 0 1c000000", inst_addr_ok, data_addr_ok, mem_addr); end
        step_begin(); inst_req = 0; step_end();
        n_vec++; if (data_addr_ok !== 1'b1 || mem_addr !== 32'h1c000900) begin n_err++; $display("FAIL lock_then_data got ok=%b addr=%h want 1 1c000900", data_addr_ok, mem_addr); end
        step_begin(); data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; step_end();
        n_vec++; if (inst_data_ok !== 1'b1) begin n_err++; $display("FAIL lock_resp0 got %b want 1", inst_data_ok); end
        step_begin(); step_end();
        n_vec++; if (data_data_ok !== 1'b1) begin n_err++; $display("FAIL lock_resp1 got %b want 1", data_data_ok); end
    endtask

    task automatic test_full();
        step_begin(); idle(); inst_req = 1; inst_addr = 32'h1c000010; mem_addr_ok = 1; step_end();
        step_begin(); inst_addr = 32'h1c000014; step_end();
        n_vec++; if (inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL full_fill got %b want 1", inst_addr_ok); end
        step_begin(); inst_addr = 32'h1c000018; step_end();
        n_vec++; if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin n_err++; $display("FAIL full_block got req=%b ok=%b want 0 0", mem_req, inst_addr_ok); end
        step_begin(); mem_data_ok = 1; mem_rdata = 32'h02000513; step_end();
        n_vec++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h02000513) begin n_err++; $display("FAIL full_pop got ok=%b rdata=%h want 1 02000513", inst_data_ok, inst_rdata); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL full_no_refill got %b want 0", mem_req); end
        step_begin(); mem_data_ok = 0; step_end();
        n_vec++; if (mem_req !== 1'b1 || inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL full_refill got req=%b ok=%b want 1 1", mem_req, inst_addr_ok); end
        step_begin(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; step_end();
        step_begin(); step_end();
        n_vec++; if (inst_data_ok !== 1'b1) begin n_err++; $display("FAIL full_drain got %b want 1", inst_data_ok); end
    endtask

    task automatic test_store();
        step_begin(); idle();
        data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h1c000803;
        data_wstrb = 4'b1000; data_wdata = 32'hab000000; mem_addr_ok = 1;
        step_end();
        n_vec++; if (mem_wr !== 1'b1 || mem_wstrb !== 4'b1000 || mem_size !== 2'd0) begin n_err++; $display("FAIL store_fields got wr=%b strb=%b size=%0d want 1 1000 0", mem_wr, mem_wstrb, mem_size); end
        n_vec++; if (mem_addr !== 32'h1c000803 || mem_wdata !== 32'hab000000 || data_addr_ok !== 1'b1) begin n_err++; $display("FAIL store_addr got addr=%h wdata=%h ok=%b", mem_addr, mem_wdata, data_addr_ok); end
        step_begin(); data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; step_end();
        n_vec++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin n_err++; $display("FAIL store_resp got d=%b i=%b want 1 0", data_data_ok, inst_data_ok); end
        step_begin(); step_end();
        n_vec++; if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin n_err++; $display("FAIL store_stray got d=%b i=%b want 0 0", data_data_ok, inst_data_ok); end
    endtask

    task automatic test_push_pop();
        bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        step_begin(); idle(); inst_req = 1; inst_addr = 32'h1c000020; mem_addr_ok = 1; step_end();
        step_begin(); inst_req = 0; data_req = 1; data_addr = 32'h1c000a00; mem_data_ok = 1; step_end();
        n_vec++; if (inst_data_ok !== 1'b1 || data_addr_ok !== 1'b1) begin n_err++; $display("FAIL pp_both got idok=%b daok=%b want 1 1", inst_data_ok, data_addr_ok); end
        step_begin(); data_req = 0; mem_addr_ok = 0; step_end();
        n_vec++; if (data_data_ok !== 1'b1) begin n_err++; $display("FAIL pp_cnt1 got %b want 1", data_data_ok); end
        step_begin(); step_end();
        n_vec++; if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin n_err++; $display("FAIL pp_empty got %b%b want 00", inst_data_ok, data_data_ok); end
        for (int i = 0; i < 5; i++) begin
            step_begin(); idle();
            inst_req = !pat[i]; data_req = pat[i]; inst_addr = 32'h1c000100 + 32'(i * 4);
            data_addr = 32'h1c000c00 + 32'(i * 4); data_size = 2'd2;
            mem_addr_ok = 1; mem_data_ok = (i > 0);
            step_end();
            n_vec++; if (data_addr_ok !== pat[i] || inst_addr_ok !== !pat[i]) begin n_err++; $display("FAIL wrap_issue%0d got i=%b d=%b", i, inst_addr_ok, data_addr_ok); end
            if (i > 0) begin
                n_vec++; if (data_data_ok !== pat[i-1] || inst_data_ok !== !pat[i-1]) begin n_err++; $display("FAIL wrap_resp%0d got i=%b d=%b want d=%b", i - 1, inst_data_ok, data_data_ok, pat[i-1]); end
            end
        end
        step_begin(); idle(); mem_data_ok = 1; step_end();
        n_vec++; if (data_data_ok !== pat[4] || inst_data_ok !== !pat[4]) begin n_err++; $display("FAIL wrap_resp4 got i=%b d=%b want d=%b", inst_data_ok, data_data_ok, pat[4]); end
    endtask

    task automatic test_reset_mid();
        step_begin(); idle(); inst_req = 1; inst_addr = 32'h1c000040; mem_addr_ok = 1; step_end();
        step_begin(); step_end();
        step_begin(); reset = 1; mem_data_ok = 1; step_end();
        n_vec++; if (mem_req !== 1'b0 || inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_err++; $display("FAIL rmid_cycle got req=%b %b%b want 0 00", mem_req, inst_data_ok, data_data_ok); end
        step_begin(); reset = 0; inst_req = 0; mem_addr_ok = 0; step_end();
        n_vec++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_err++; $display("FAIL rmid_stray got %b%b want 00", inst_data_ok, data_data_ok); end
        // cnt=1 with a data lock, then reset
        step_begin(); idle(); inst_req = 1; inst_addr = 32'h1c000050; mem_addr_ok = 1; step_end();
        step_begin(); inst_req = 0; mem_addr_ok = 0; data_req = 1; data_addr = 32'h1c000e00; data_size = 2'd2; step_end();
        step_begin(); reset = 1; mem_addr_ok = 1; step_end();
        n_vec++; if (mem_req !== 1'b0 || data_addr_ok !== 1'b0) begin n_err++; $display("FAIL rmid_lock_cycle got req=%b ok=%b want 0 0", mem_req, data_addr_ok); end
        step_begin(); reset = 0; data_req = 0; inst_req = 1; inst_addr = 32'h1c000060; mem_addr_ok = 0; mem_data_ok = 1; step_end();
        n_vec++; if (mem_addr !== 32'h1c000060 || mem_req !== 1'b1) begin n_err++; $display("FAIL rmid_lock_clear got addr=%h req=%b want 1c000060 1", mem_addr, mem_req); end
        n_vec++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_err++; $display("FAIL rmid_lock_stray got %b%b want 00", inst_data_ok, data_data_ok); end
        step_begin(); mem_data_ok = 0; mem_addr_ok = 1; step_end();
        step_begin(); idle(); mem_data_ok = 1; step_end();
        n_vec++; if (inst_data_ok !== 1'b1) begin n_err++; $display("FAIL rmid_recover got %b want 1", inst_data_ok); end
    endtask

    task automatic test_random();
        bit i_act = 0, d_act = 0, i_acc = 0, d_acc = 0;
        step_begin(); idle(); step_end();
        for (int n = 0; n < 400; n++) begin
            step_begin();
            if (i_acc) i_act = 0;
            if (d_acc) d_act = 0;
            if (!i_act && $urandom_range(0, 1) == 1) begin
                i_act = 1;
                inst_addr = $urandom() & 32'hffff_fffc;
            end
            if (!d_act && $urandom_range(0, 1) == 1) begin
                d_act = 1;
                data_wr = 1'($urandom_range(0, 1));
                data_size = 2'($urandom_range(0, 2));
                data_wstrb = 4'($urandom());
                data_addr = $urandom();
                data_wdata = $urandom();
            end
            inst_req = i_act;
            data_req = d_act;
            mem_addr_ok = ($urandom_range(0, 2) != 0);
            mem_data_ok = 1'($urandom_range(0, 1));
            mem_rdata = $urandom();
            step_end();
            i_acc = e_iaok;
            d_acc = e_daok;
            n_vec++; if (mem_req !== e_req) begin n_err++; $display("FAIL rnd%0d mem_req got %b want %b", n, mem_req, e_req); end
            n_vec++; if (inst_addr_ok !== e_iaok || data_addr_ok !== e_daok) begin n_err++; $display("FAIL rnd%0d addr_ok got %b%b want %b%b", n, inst_addr_ok, data_addr_ok, e_iaok, e_daok); end
            n_vec++; if (inst_data_ok !== e_idok || data_data_ok !== e_ddok) begin n_err++; $display("FAIL rnd%0d data_ok got %b%b want %b%b", n, inst_data_ok, data_data_ok, e_idok, e_ddok); end
            n_vec++; if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin n_err++; $display("FAIL rnd%0d addr/wdata got %h/%h want %h/%h", n, mem_addr, mem_wdata, e_addr, e_wdata); end
            n_vec++; if (mem_wr !== e_wr || mem_size !== e_size || mem_wstrb !== e_strb) begin n_err++; $display("FAIL rnd%0d ctl got %b/%0d/%b want %b/%0d/%b", n, mem_wr, mem_size, mem_wstrb, e_wr, e_size, e_strb); end
            n_vec++; if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin n_err++; $display("FAIL rnd%0d rdata got %h/%h want %h", n, inst_rdata, data_rdata, mem_rdata); end
        end
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_contention();
        test_lock();
        test_full();
        test_store();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
